// File: rtl/ad7606_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ad7606_seq_ctrl
// Purpose  : Periodic AD7606 conversion/readout sequencer packing channel
//            pairs into a downstream FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ad7606_seq_ctrl #(
  parameter int PERIOD_MIN = 64,
  parameter int CONV_LOW   = 2,
  parameter int RD_LOW     = 2,
  parameter int RD_HIGH    = 2,
  parameter int BUSY_TO    = 1024,
  parameter int FIFO_DEPTH = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] period,
  input  logic        busy,
  input  logic [15:0] data_in,
  output logic        conv,
  output logic        cs_n,
  output logic        rd_n,
  input  logic [8:0]  fifo_usedw,
  output logic        fifo_wrreq,
  output logic [31:0] fifo_data,
  output logic        frame_done,
  output logic [15:0] overrun_cnt,
  output logic        timeout_err
);

  localparam int              TO_W         = $clog2(BUSY_TO + 1);
  localparam logic [15:0]     C_PERIOD_MIN = 16'(PERIOD_MIN);
  localparam logic [7:0]      C_CONV_LAST  = 8'(CONV_LOW - 1);
  localparam logic [7:0]      C_RDLO_LAST  = 8'(RD_LOW - 1);
  localparam logic [7:0]      C_RDHI_LAST  = 8'(RD_HIGH - 1);
  localparam logic [TO_W-1:0] C_BUSY_TO    = TO_W'(BUSY_TO);
  localparam logic [9:0]      C_USEDW_MAX  = 10'(FIFO_DEPTH - 4);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV    = 3'd1,
    WAIT_BH = 3'd2,
    WAIT_BL = 3'd3,
    RD_LO   = 3'd4,
    RD_HI   = 3'd5,
    WRITE   = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_busy_m;
  logic            r_busy_s;
  logic [15:0]     r_per_cnt;
  logic [15:0]     r_per_len;
  logic [15:0]     w_period_eff;
  logic            w_tick;
  logic            w_room;
  logic            w_waiting;
  logic            w_to_expired;
  logic [7:0]      r_sub;
  logic [2:0]      r_ch;
  logic [TO_W-1:0] r_to;
  logic [31:0]     r_data;
  logic            r_done;
  logic [15:0]     r_ovr;
  logic            r_timeout;

  always_comb begin
    w_period_eff = (period < C_PERIOD_MIN) ? C_PERIOD_MIN : period;
    w_tick       = enable && (r_per_cnt == r_per_len - 16'd1);
    w_room       = ({1'b0, fifo_usedw} <= C_USEDW_MAX);
    w_waiting    = (r_state == WAIT_BH) || (r_state == WAIT_BL);
    w_to_expired = (r_to == C_BUSY_TO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_m <= 1'b0;
      r_busy_s <= 1'b0;
    end else begin
      r_busy_m <= busy;
      r_busy_s <= r_busy_m;
    end
  end

  // The period is latched at every reload, and continuously while disabled so
  // the first interval after enable uses the current input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= '0;
      r_per_len <= C_PERIOD_MIN;
    end else if (!enable || w_tick) begin
      r_per_cnt <= '0;
      r_per_len <= w_period_eff;
    end else begin
      r_per_cnt <= r_per_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    conv        = 1'b1;
    cs_n        = 1'b1;
    rd_n        = 1'b1;
    fifo_wrreq  = 1'b0;
    fifo_data   = r_data;
    frame_done  = r_done;
    overrun_cnt = r_ovr;
    timeout_err = r_timeout;
    case (r_state)
      IDLE: if (w_tick && w_room) w_state_nxt = CONV;
      CONV: begin
        conv = 1'b0;
        if (r_sub == C_CONV_LAST) w_state_nxt = WAIT_BH;
      end
      WAIT_BH: begin
        if (w_to_expired)  w_state_nxt = IDLE;
        else if (r_busy_s) w_state_nxt = WAIT_BL;
      end
      WAIT_BL: begin
        if (w_to_expired)   w_state_nxt = IDLE;
        else if (!r_busy_s) w_state_nxt = RD_LO;
      end
      RD_LO: begin
        cs_n = 1'b0;
        rd_n = 1'b0;
        if (r_sub == C_RDLO_LAST) w_state_nxt = r_ch[0] ? WRITE : RD_HI;
      end
      // WRITE doubles as the first rd_n-high cycle after an odd channel.
      WRITE: begin
        cs_n        = 1'b0;
        fifo_wrreq  = 1'b1;
        w_state_nxt = RD_HI;
      end
      RD_HI: begin
        cs_n = 1'b0;
        if (r_sub >= C_RDHI_LAST) w_state_nxt = (r_ch == 3'd7) ? IDLE : RD_LO;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub     <= '0;
      r_ch      <= '0;
      r_to      <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_ovr     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_tick && (r_state != IDLE || !w_room) && r_ovr != 16'hFFFF)
        r_ovr <= r_ovr + 16'd1;
      if (w_state_nxt != r_state) r_sub <= (r_state == WRITE) ? 8'd1 : 8'd0;
      else                        r_sub <= r_sub + 8'd1;
      r_to <= w_waiting ? r_to + 1'b1 : '0;
      if (w_waiting && w_to_expired) r_timeout <= 1'b1;
      if (r_state == RD_LO && r_sub == C_RDLO_LAST) begin
        if (r_ch[0]) r_data[15:0]  <= data_in;
        else         r_data[31:16] <= data_in;
      end
      if (r_state == WAIT_BL)                           r_ch <= '0;
      else if (r_state == RD_HI && w_state_nxt == RD_LO) r_ch <= r_ch + 3'd1;
      if (r_state == RD_HI && w_state_nxt == IDLE) r_done <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad7606_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad7606_seq_ctrl
// Purpose  : Randomised self-checking bench with an AD7606 bus/busy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad7606_seq_ctrl;
  localparam int PERIOD_MIN = 64;
  localparam int CONV_LOW   = 2;
  localparam int RD_LOW     = 2;
  localparam int RD_HIGH    = 2;
  localparam int BUSY_TO    = 1024;
  localparam int FIFO_DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] period;
  logic        busy;
  logic [15:0] data_in;
  logic [8:0]  fifo_usedw;
  logic        conv, cs_n, rd_n, fifo_wrreq, frame_done, timeout_err;
  logic [31:0] fifo_data;
  logic [15:0] overrun_cnt;

  ad7606_seq_ctrl #(
    .PERIOD_MIN(PERIOD_MIN), .CONV_LOW(CONV_LOW), .RD_LOW(RD_LOW),
    .RD_HIGH(RD_HIGH), .BUSY_TO(BUSY_TO), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .busy(busy),
    .data_in(data_in), .conv(conv), .cs_n(cs_n), .rd_n(rd_n),
    .fifo_usedw(fifo_usedw), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .frame_done(frame_done), .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected conv start cycles and expected FIFO words
  int          exp_start[$];
  logic [31:0] exp_wr[$];
  logic [15:0] vals[8];
  int  cur_b       = 10;
  int  stuck_left  = 0;
  bit  fixed_data  = 1'b0;
  int  busy_t      = -1;
  int  rd_ch       = -1;
  int  low_cnt     = 0;
  int  wr_in_frame = 0;
  int  done_count  = 0;
  int  to_watch    = 0;
  int  lat         = 0;
  logic prev_conv = 1'b1, prev_cs = 1'b1, prev_rd = 1'b1, prev_to = 1'b0;

  // ADC model and scoreboard, evaluated away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
      busy_t = -1;
      data_in = '0;
      rd_ch = -1;
      low_cnt = 0;
      wr_in_frame = 0;
      done_count = 0;
      exp_wr.delete();
      exp_start.delete();
    end else begin
      if (busy_t >= 0) busy_t++;
      if (prev_conv && !conv) begin
        if (exp_start.size() == 0) check("conv_unexpected", cyc, 0);
        else                       check("conv_time", cyc, exp_start.pop_front());
        if (stuck_left > 0) begin
          stuck_left--;
          to_watch = cyc;
          busy_t = -1;
        end else begin
          busy_t = 0;
          for (int i = 0; i < 8; i++) vals[i] = fixed_data ? 16'(i + 1) : 16'($urandom);
          for (int i = 0; i < 4; i++) exp_wr.push_back({vals[2*i], vals[2*i+1]});
        end
      end
      busy = (busy_t >= 2 && busy_t < 2 + cur_b);
      if (busy_t > cur_b + 2) busy_t = -1;

      if (prev_cs && !cs_n) rd_ch = -1;
      if (!rd_n) begin
        if (prev_rd) begin rd_ch++; low_cnt = 1; end
        else low_cnt++;
      end
      // Bus is only valid late in the rd_n low phase
      if (!rd_n && low_cnt >= RD_LOW && rd_ch >= 0 && rd_ch < 8) data_in = vals[rd_ch];
      else data_in = 16'($urandom);

      if (fifo_wrreq) begin
        if (exp_wr.size() == 0) check("wr_unexpected", fifo_data, 32'hFFFF_FFFF);
        else                    check("wr_data", fifo_data, exp_wr.pop_front());
        wr_in_frame++;
      end
      if (frame_done) begin
        check("frame_writes", wr_in_frame, 4);
        wr_in_frame = 0;
        done_count++;
      end
      if (!prev_to && timeout_err) begin
        lat = cyc - to_watch;
        check("timeout_latency_in_window",
              (lat >= CONV_LOW + BUSY_TO && lat <= CONV_LOW + BUSY_TO + 6), 1);
      end
    end
    prev_conv = conv;
    prev_cs   = cs_n;
    prev_rd   = rd_n;
    prev_to   = timeout_err;
  end

  int ovr_exp    = 0;
  int frames_exp = 0;
  bit to_exp     = 1'b0;

  // Tick schedule from max(period, PERIOD_MIN); a tick starts a frame only if
  // the previous frame's worst-case length has elapsed and the FIFO has room.
  task automatic run_scn(input int per, input int b, input int stuck, input int usedw,
                         input int nticks, input int settle);
    int p, c0, tick, busy_until, starts;
    p = (per < PERIOD_MIN) ? PERIOD_MIN : per;
    period = 16'(per);
    fifo_usedw = 9'(usedw);
    cur_b = b;
    stuck_left = stuck;
    @(negedge clk);
    #1 enable = 1'b1;
    c0 = cyc;
    busy_until = -1000000;
    starts = 0;
    for (int k = 1; k <= nticks; k++) begin
      tick = c0 + k * p;
      if (tick < busy_until || usedw > FIFO_DEPTH - 4) begin
        if (ovr_exp < 65535) ovr_exp++;
      end else begin
        exp_start.push_back(tick);
        if (starts < stuck) begin
          busy_until = tick + CONV_LOW + BUSY_TO + 12;
          to_exp = 1'b1;
        end else begin
          busy_until = tick + CONV_LOW + b + 8 * (RD_LOW + RD_HIGH) + 10;
          frames_exp++;
        end
        starts++;
      end
    end
    while (cyc < c0 + nticks * p) @(negedge clk);
    #1 enable = 1'b0;
    repeat (settle) @(negedge clk);
    #1;
    check("conv_missing", exp_start.size(), 0);
    check("words_missing", exp_wr.size(), 0);
    check("overrun_cnt", overrun_cnt, ovr_exp);
    check("frame_count", done_count, frames_exp);
    check("timeout_err", timeout_err, to_exp);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_conv"}, conv, 1);
    check({pfx, "_cs_n"}, cs_n, 1);
    check({pfx, "_rd_n"}, rd_n, 1);
    check({pfx, "_wrreq"}, fifo_wrreq, 0);
    check({pfx, "_data"}, fifo_data, 0);
    check({pfx, "_frame_done"}, frame_done, 0);
    check({pfx, "_overrun"}, overrun_cnt, 0);
    check({pfx, "_timeout"}, timeout_err, 0);
  endtask

  bit found;
  int c_mid;

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    period = 16'd100;
    fifo_usedw = '0;
    #3 check_reset_outputs("reset");
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b1;

    fixed_data = 1'b1;
    run_scn(100, 50, 0, 0, 3, 300);
    fixed_data = 1'b0;
    for (int i = 0; i < 3; i++)
      run_scn(int'($urandom_range(120, 64)), int'($urandom_range(20, 5)), 0, 0, 3, 150);
    run_scn(10, 15, 0, 0, 4, 150);
    run_scn(100, 10, 0, 509, 1, 150);
    run_scn(100, 10, 0, 508, 1, 150);
    run_scn(100, 150, 0, 0, 4, 300);
    run_scn(100, 10, 1, 0, 12, 300);

    // Reset while channel 3 is being read
    period = 16'd100;
    fifo_usedw = '0;
    cur_b = 10;
    @(negedge clk);
    #1 enable = 1'b1;
    c_mid = cyc;
    exp_start.push_back(c_mid + 100);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      #1;
      if (!cs_n && !rd_n && rd_ch == 3) found = 1'b1;
    end
    check("reach_ch3_read", found, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    enable = 1'b0;
    ovr_exp = 0;
    frames_exp = 0;
    to_exp = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    run_scn(100, 12, 0, 0, 2, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ad7606_seq_ctrl.md
AD7606_SEQ_CTRL -- requirements
Module: ad7606_seq_ctrl

Interface
REQ-001 Parameter: PERIOD_MIN, 64, minimum sample period in clk cycles; smaller period inputs are clamped to it.
REQ-002 Parameter: CONV_LOW, 2, conv low-pulse width in cycles.
REQ-003 Parameter: RD_LOW, 2, rd_n low width in cycles; RD_HIGH, 2, rd_n high width in cycles.
REQ-004 Parameter: BUSY_TO, 1024, busy wait timeout in cycles; FIFO_DEPTH, 512, downstream FIFO depth.
REQ-005 Port: clk  input  1  system clock; the block has one clock.
REQ-006 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: enable  input  1  level; 1 = periodic sampling runs.
REQ-008 Port: period  input  16  sample period in clk cycles, sampled when the period counter reloads.
REQ-009 Port: busy  input  1  AD7606 BUSY, synchronised internally through 2 flops.
REQ-010 Port: data_in  input  16  AD7606 parallel data bus.
REQ-011 Port: conv  output  1  CONVST, idle high, active-low pulse.
REQ-012 Port: cs_n  output  1  chip select, low for the whole 8-channel read.
REQ-013 Port: rd_n  output  1  read strobe, idle high.
REQ-014 Port: fifo_usedw  input  9  fill level of the downstream FIFO.
REQ-015 Port: fifo_wrreq  output  1  single-cycle FIFO write strobe.
REQ-016 Port: fifo_data  output  32  packed channel pair.
REQ-017 Port: frame_done  output  1  single-cycle pulse after the 4th write of a frame.
REQ-018 Port: overrun_cnt  output  16  saturating count of dropped sample ticks.
REQ-019 Port: timeout_err  output  1  sticky busy-timeout flag, cleared only by reset.

Function
REQ-020 Period counter: runs while enable=1 and issues a tick every max(period,PERIOD_MIN) cycles; first tick comes that many cycles after enable rises; enable=0 clears the counter.
REQ-021 States: IDLE, CONV, WAIT_BH, WAIT_BL, RD_LO, RD_HI, WRITE.
REQ-022 IDLE + tick + fifo_usedw <= FIFO_DEPTH-4: go to CONV; conv=0 for CONV_LOW cycles.
REQ-023 IDLE + tick + fifo_usedw > FIFO_DEPTH-4: stay IDLE, overrun_cnt+1, no conv pulse.
REQ-024 Tick in any state other than IDLE: tick dropped, overrun_cnt+1.
REQ-025 overrun_cnt saturates at 16'hFFFF.
REQ-026 CONV to WAIT_BH: wait for synchronised busy=1. WAIT_BH to WAIT_BL: wait for busy=0.
REQ-027 Busy timeout: the combined WAIT_BH+WAIT_BL time exceeds BUSY_TO cycles -> timeout_err=1, return to IDLE, no FIFO writes.
REQ-028 On busy=0, cs_n goes low and the block enters RD_LO with channel index 0.
REQ-029 Each channel: rd_n=0 for RD_LOW cycles; data_in is captured on the last low cycle; rd_n=1 for RD_HIGH cycles.
REQ-030 Channel order is 0..7.
REQ-031 Packing: even channel to fifo_data[31:16], odd channel to fifo_data[15:0].
REQ-032 fifo_wrreq=1 for exactly one cycle in the cycle after the odd channel is captured, with fifo_data valid in that same cycle.
REQ-033 Each frame produces exactly 4 FIFO writes.
REQ-034 After the 8th channel's RD_HI: cs_n=1, frame_done=1 for one cycle, return to IDLE.
REQ-035 enable falling mid-frame: the current frame completes, then the block stays IDLE.
REQ-036 fifo_usedw is checked only at the frame start; the room for 4 words is guaranteed by REQ-022.

Reset
REQ-037 While rst_n=0: state=IDLE; conv=1, cs_n=1, rd_n=1, fifo_wrreq=0, fifo_data=0, frame_done=0, overrun_cnt=0, timeout_err=0; period counter and channel index are 0.
REQ-038 Reset asserted mid-frame aborts the frame immediately: no partial write, and outputs go to their REQ-037 values asynchronously.

Verification
REQ-039 Basic frame: period=100, enable=1, busy model high for 50 cycles after conv, data_in=ch+1 -> conv pulse every 100 cycles; writes 32'h00010002, 00030004, 00050006, 00070008; one frame_done per frame.
REQ-040 Clamp: period=10 -> ticks every 64 cycles; overrun_cnt stays 0 when a frame fits in 64 cycles.
REQ-041 Backpressure: fifo_usedw=509 at tick -> no conv, overrun_cnt=1. fifo_usedw=508 -> frame runs with 4 writes.
REQ-042 Busy stuck low: busy never rises -> timeout_err=1 after 1024 cycles; no wrreq; next tick starts a new frame normally.
REQ-043 Slow busy: busy high for 150 cycles with period=100 -> overlapping tick dropped, overrun_cnt increments by 1 per dropped tick.
REQ-044 Reset mid-read: assert rst_n=0 while rd_n=0 on channel 3 -> all outputs take their REQ-037 values with no clock edge; after release, the first frame writes the full 4 words.
